// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes and default channel widths.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int ADDR_WIDTH_DEF = 3;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int STRB_WIDTH_DEF = 4;
   localparam int RESP_WIDTH_DEF = 2;
   localparam int LEN_WIDTH_DEF  = 8;
   localparam int SIZE_WIDTH_DEF = 3;
   localparam int BURST_WIDTH_DEF = 2;
   localparam int CACHE_WIDTH_DEF = 4;
   localparam int PROT_WIDTH_DEF  = 3;

endpackage

// File: rtl/axi_slave_mem.sv
// Word memory with a per-word "written" flag. One synchronous write port,
// one combinational read port, so a read on the same edge as a write to the
// same word observes the previous contents.
module axi_slave_mem #(
   parameter int addr_width = 3,
   parameter int data_width = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  we_i,
   input  logic [addr_width-1:0] waddr_i,
   input  logic [data_width-1:0] wdata_i,
   input  logic [addr_width-1:0] raddr_i,
   output logic [data_width-1:0] rdata_o,
   output logic                  rwritten_o
);

   localparam int DEPTH = 2 ** addr_width;

   logic [data_width-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      written_q;

   // Storage update: reset clears every word and flag, a write marks its word.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         written_q <= '0;
      end else if (we_i) begin
         mem_q[waddr_i]     <= wdata_i;
         written_q[waddr_i] <= 1'b1;
      end
   end

   assign rdata_o    = mem_q[raddr_i];
   assign rwritten_o = written_q[raddr_i];

endmodule

// File: rtl/axi_slave.sv
// Single-beat AXI4 slave in front of a small register memory.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// both valid and ready are high. The slave never retracts an asserted
// bvalid/rvalid and keeps its payload stable until the matching ready.
// awready/wready are low while their capture register is occupied;
// arready is low while read data is waiting for rready.
module axi_slave
   import axi_pkg::*;
#(
   parameter int addr_width   = ADDR_WIDTH_DEF,
   parameter int len          = LEN_WIDTH_DEF,
   parameter int size         = SIZE_WIDTH_DEF,
   parameter int burst_length = BURST_WIDTH_DEF,
   parameter int cache        = CACHE_WIDTH_DEF,
   parameter int prot         = PROT_WIDTH_DEF,
   parameter int data_width   = DATA_WIDTH_DEF,
   parameter int strb         = STRB_WIDTH_DEF,
   parameter int resp         = RESP_WIDTH_DEF
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   // write address
   input  logic                    awid,
   input  logic [addr_width-1:0]   awaddr,
   input  logic [len-1:0]          awlen,
   input  logic [size-1:0]         awsize,
   input  logic [burst_length-1:0] awburst,
   input  logic                    awlock,
   input  logic [cache-1:0]        awcache,
   input  logic [prot-1:0]         awprot,
   input  logic [3:0]              awqos,
   input  logic [3:0]              awregion,
   input  logic                    awuser,
   input  logic                    awvalid,
   output logic                    awready,
   // write data
   input  logic                    wid,
   input  logic [data_width-1:0]   wdata,
   input  logic [strb-1:0]         wstrb,
   input  logic                    wlast,
   input  logic                    wuser,
   input  logic                    wvalid,
   output logic                    wready,
   // write response
   output logic                    bid,
   output logic [resp-1:0]         bresp,
   output logic                    buser,
   output logic                    bvalid,
   input  logic                    bready,
   // read address
   input  logic                    arid,
   input  logic [addr_width-1:0]   araddr,
   input  logic [len-1:0]          arlen,
   input  logic [size-1:0]         arsize,
   input  logic [burst_length-1:0] arburst,
   input  logic                    arlock,
   input  logic [cache-1:0]        arcache,
   input  logic [prot-1:0]         arprot,
   input  logic [3:0]              arqos,
   input  logic [3:0]              arregion,
   input  logic                    aruser,
   input  logic                    arvalid,
   output logic                    arready,
   // read data
   output logic                    rid,
   output logic [data_width-1:0]   rdata,
   output logic [resp-1:0]         rresp,
   output logic                    rlast,
   output logic                    ruser,
   output logic                    rvalid,
   input  logic                    rready
);

   logic                  aw_full_q, aw_full_d;
   logic                  w_full_q, w_full_d;
   logic [addr_width-1:0] awaddr_q, awaddr_d;
   logic                  awid_q, awid_d;
   logic [data_width-1:0] wdata_q, wdata_d;
   logic                  bvalid_q, bvalid_d;
   logic [resp-1:0]       bresp_q, bresp_d;
   logic                  bid_q, bid_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rid_q, rid_d;
   logic                  rlast_q, rlast_d;
   logic [data_width-1:0] rdata_q, rdata_d;
   logic [resp-1:0]       rresp_q, rresp_d;

   logic                  mem_we;
   logic [data_width-1:0] mem_rdata;
   logic                  mem_rwritten;
   logic                  unused_inputs;

   // Burst, cache, protection, strobe and user sidebands have no effect here.
   assign unused_inputs = ^{awlen, awsize, awburst, awlock, awcache, awprot,
                            awqos, awregion, awuser, wid, wstrb, wlast, wuser,
                            arlen, arsize, arburst, arlock, arcache, arprot,
                            arqos, arregion, aruser};

   assign awready = !aw_full_q;
   assign wready  = !w_full_q;
   assign arready = !rvalid_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign bid     = bid_q;
   assign buser   = 1'b0;
   assign rvalid  = rvalid_q;
   assign rid     = rid_q;
   assign rlast   = rlast_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign ruser   = 1'b0;

   // Commit the captured write once address and data are both held and no
   // response is outstanding; the bvalid_q term stops a second commit.
   assign mem_we = aw_full_q && w_full_q && !bvalid_q;

   axi_slave_mem #(
      .addr_width (addr_width),
      .data_width (data_width)
   ) u_mem (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .we_i       (mem_we),
      .waddr_i    (awaddr_q),
      .wdata_i    (wdata_q),
      .raddr_i    (araddr),
      .rdata_o    (mem_rdata),
      .rwritten_o (mem_rwritten)
   );

   // Next-state for the write capture, write response and read data registers.
   always_comb begin
      aw_full_d = aw_full_q;
      w_full_d  = w_full_q;
      awaddr_d  = awaddr_q;
      awid_d    = awid_q;
      wdata_d   = wdata_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      bid_d     = bid_q;
      rvalid_d  = rvalid_q;
      rid_d     = rid_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      if (awvalid && !aw_full_q) begin
         aw_full_d = 1'b1;
         awaddr_d  = awaddr;
         awid_d    = awid;
      end
      if (wvalid && !w_full_q) begin
         w_full_d = 1'b1;
         wdata_d  = wdata;
      end
      if (mem_we) begin
         bvalid_d = 1'b1;
         bresp_d  = resp'(RESP_OKAY);
         bid_d    = awid_q;
      end
      if (bvalid_q && bready) begin
         bvalid_d  = 1'b0;
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
      end

      if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end
      if (arvalid && !rvalid_q) begin
         rvalid_d = 1'b1;
         rid_d    = arid;
         rlast_d  = 1'b1;
         if (mem_rwritten) begin
            rdata_d = mem_rdata;
            rresp_d = resp'(RESP_OKAY);
         end else begin
            rdata_d = '0;
            rresp_d = resp'(RESP_SLVERR);
         end
      end
   end

   // Channel state registers; reset abandons any transaction in flight.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         awaddr_q  <= '0;
         awid_q    <= 1'b0;
         wdata_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         bid_q     <= 1'b0;
         rvalid_q  <= 1'b0;
         rid_q     <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         awaddr_q  <= awaddr_d;
         awid_q    <= awid_d;
         wdata_q   <= wdata_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         bid_q     <= bid_d;
         rvalid_q  <= rvalid_d;
         rid_q     <= rid_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

endmodule

// File: tb/tb_axi_slave.sv
// Directed bench for axi_slave: a table of write/read records plus hand
// sequences for concurrency, same-edge read-after-write and mid-flight reset.
module tb_axi_slave;

   localparam logic [31:0] OK  = 32'd0;
   localparam logic [31:0] ERR = 32'd2;

   // clock / reset
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   // DUT signals
   logic        awid = 1'b0, awvalid = 1'b0, awready;
   logic [2:0]  awaddr = 3'd0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] wdata = 32'd0;
   logic        bid, buser, bvalid, bready = 1'b0;
   logic [1:0]  bresp;
   logic        arid = 1'b0, arvalid = 1'b0, arready;
   logic [2:0]  araddr = 3'd0;
   logic        rid, rlast, ruser, rvalid, rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   int tests_run = 0;
   int fails = 0;

   axi_slave dut (
      .aclk(aclk), .aresetn(aresetn),
      .awid(awid), .awaddr(awaddr), .awlen(8'd0), .awsize(3'd2), .awburst(2'd1),
      .awlock(1'b0), .awcache(4'd0), .awprot(3'd0), .awqos(4'd0), .awregion(4'd0),
      .awuser(1'b0), .awvalid(awvalid), .awready(awready),
      .wid(1'b0), .wdata(wdata), .wstrb(4'hF), .wlast(1'b1), .wuser(1'b0),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(8'd0), .arsize(3'd2), .arburst(2'd1),
      .arlock(1'b0), .arcache(4'd0), .arprot(3'd0), .arqos(4'd0), .arregion(4'd0),
      .aruser(1'b0), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
      .rvalid(rvalid), .rready(rready)
   );

   // scoreboard check
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // order: 0 = AW then W, 1 = W then AW, 2 = both on one edge
   task automatic do_write(input int order, input logic [2:0] addr, input logic id,
                           input logic [31:0] data);
      if (order == 0) begin
         awvalid = 1'b1; awaddr = addr; awid = id;
         @(negedge aclk);
         check("awready_low_after_aw", 32'(awready), 0);
         check("wready_still_high", 32'(wready), 1);
         awvalid = 1'b0;
         wvalid = 1'b1; wdata = data;
         @(negedge aclk);
      end else if (order == 1) begin
         wvalid = 1'b1; wdata = data;
         @(negedge aclk);
         check("wready_low_after_w", 32'(wready), 0);
         check("no_bvalid_on_w_only", 32'(bvalid), 0);
         wvalid = 1'b0;
         awvalid = 1'b1; awaddr = addr; awid = id;
         @(negedge aclk);
      end else begin
         awvalid = 1'b1; awaddr = addr; awid = id;
         wvalid = 1'b1; wdata = data;
         @(negedge aclk);
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("bvalid_not_early", 32'(bvalid), 0);
      @(negedge aclk);
      check("bvalid_rise", 32'(bvalid), 1);
      check("bresp_okay", 32'(bresp), OK);
      check("bid", 32'(bid), 32'(id));
      @(negedge aclk);
      check("bvalid_held", 32'(bvalid), 1);
      check("awready_low_while_b", 32'(awready), 0);
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      check("bvalid_cleared", 32'(bvalid), 0);
      check("awready_back", 32'(awready), 1);
      check("wready_back", 32'(wready), 1);
   endtask

   task automatic do_read(input logic [2:0] addr, input logic id,
                          input logic [31:0] exp_data, input logic [31:0] exp_resp);
      arvalid = 1'b1; araddr = addr; arid = id;
      @(negedge aclk);
      arvalid = 1'b0;
      check("rvalid_rise", 32'(rvalid), 1);
      check("arready_low", 32'(arready), 0);
      check("rdata", rdata, exp_data);
      check("rresp", 32'(rresp), exp_resp);
      check("rid", 32'(rid), 32'(id));
      check("rlast", 32'(rlast), 1);
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      check("rvalid_cleared", 32'(rvalid), 0);
      check("arready_back", 32'(arready), 1);
   endtask

   typedef struct {
      logic        do_write;
      int          order;
      logic [2:0]  awaddr;
      logic        awid;
      logic [31:0] wdata;
      logic [2:0]  araddr;
      logic        arid;
      logic [31:0] exp_rdata;
      logic [31:0] exp_rresp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b1, 0, 3'd1, 1'b1, 32'd5,          3'd1, 1'b0, 32'd5,          OK};
      vecs[1] = '{1'b1, 1, 3'd2, 1'b0, 32'd10,         3'd2, 1'b1, 32'd10,         OK};
      vecs[2] = '{1'b1, 2, 3'd3, 1'b1, 32'd20,         3'd3, 1'b1, 32'd20,         OK};
      vecs[3] = '{1'b1, 2, 3'd7, 1'b0, 32'hDEADBEEF,   3'd7, 1'b0, 32'hDEADBEEF,   OK};
      vecs[4] = '{1'b0, 0, 3'd0, 1'b0, 32'd0,          3'd5, 1'b1, 32'd0,          ERR};
      vecs[5] = '{1'b1, 0, 3'd0, 1'b0, 32'h0000A5A5,   3'd1, 1'b0, 32'd5,          OK};

      // reset values
      repeat (2) @(negedge aclk);
      check("rst_awready", 32'(awready), 1);
      check("rst_wready", 32'(wready), 1);
      check("rst_arready", 32'(arready), 1);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_bresp", 32'(bresp), 0);
      check("rst_bid", 32'(bid), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rdata", rdata, 0);
      check("rst_rresp", 32'(rresp), 0);
      check("rst_rid", 32'(rid), 0);
      check("rst_rlast", 32'(rlast), 0);
      check("rst_buser", 32'(buser), 0);
      check("rst_ruser", 32'(ruser), 0);
      aresetn = 1'b1;
      @(negedge aclk);

      // table-driven write/read records
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].do_write)
            do_write(vecs[i].order, vecs[i].awaddr, vecs[i].awid, vecs[i].wdata);
         do_read(vecs[i].araddr, vecs[i].arid, vecs[i].exp_rdata, vecs[i].exp_rresp);
      end

      // write addr 2 concurrently with a read of addr 1
      awvalid = 1'b1; awaddr = 3'd2; awid = 1'b1;
      wvalid = 1'b1; wdata = 32'h22;
      arvalid = 1'b1; araddr = 3'd1; arid = 1'b0;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("conc_rvalid", 32'(rvalid), 1);
      check("conc_rdata", rdata, 32'd5);
      @(negedge aclk);
      check("conc_bvalid", 32'(bvalid), 1);
      check("conc_rvalid_held", 32'(rvalid), 1);
      check("conc_rdata_held", rdata, 32'd5);
      bready = 1'b1; rready = 1'b1;
      @(negedge aclk);
      bready = 1'b0; rready = 1'b0;
      check("conc_b_done", 32'(bvalid), 0);
      check("conc_r_done", 32'(rvalid), 0);
      do_read(3'd2, 1'b1, 32'h22, OK);

      // read of addr 3 on the same edge its new value is committed
      awvalid = 1'b1; awaddr = 3'd3; awid = 1'b0;
      wvalid = 1'b1; wdata = 32'h33;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      arvalid = 1'b1; araddr = 3'd3; arid = 1'b1;
      @(negedge aclk);
      arvalid = 1'b0;
      check("raw_bvalid", 32'(bvalid), 1);
      check("raw_rvalid", 32'(rvalid), 1);
      check("raw_old_data", rdata, 32'd20);
      check("raw_rresp", 32'(rresp), OK);
      bready = 1'b1; rready = 1'b1;
      @(negedge aclk);
      bready = 1'b0; rready = 1'b0;
      do_read(3'd3, 1'b0, 32'h33, OK);

      // reset while a write response is pending
      awvalid = 1'b1; awaddr = 3'd4; awid = 1'b1;
      wvalid = 1'b1; wdata = 32'h44;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk);
      check("pre_rst_bvalid", 32'(bvalid), 1);
      #1 aresetn = 1'b0;
      #1;
      check("async_rst_bvalid", 32'(bvalid), 0);
      check("async_rst_awready", 32'(awready), 1);
      check("async_rst_wready", 32'(wready), 1);
      check("async_rst_bid", 32'(bid), 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      do_read(3'd4, 1'b0, 32'd0, ERR);
      do_read(3'd1, 1'b1, 32'd0, ERR);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   // run-time guard
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected end before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axi_slave.md
# axi_slave

Single-beat AXI4 slave fronting an 8-entry × 32-bit register memory. Write address and write data are accepted independently, in either order or together; a write response follows once both have been captured. Reads return the stored word one cycle after the address handshake, and reads of never-written entries are flagged with SLVERR. It is the leaf memory target used to exercise AXI masters and interconnect in the AMBA subsystem.

## Interface
Parameters:
- addr_width, 3: address bits; memory depth 2^addr_width.
- len, 8 / size, 3 / burst_length, 2 / cache, 4 / prot, 3: widths of AxLEN/AxSIZE/AxBURST/AxCACHE/AxPROT; accepted and ignored.
- data_width, 32: data bus width.
- strb, 4: WSTRB width; ignored.
- resp, 2: xRESP width.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- Write address channel: awid, awaddr[addr_width], awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid (all in); awready out 1.
- Write data channel: wid, wdata[data_width], wstrb[strb], wlast, wuser, wvalid (all in); wready out 1.
- Write response channel: bid out 1, bresp out resp, buser out 1, bvalid out 1; bready in 1.
- Read address channel: arid, araddr[addr_width], arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid (all in); arready out 1.
- Read data channel: rid out 1, rdata out data_width, rresp out resp, rlast out 1, ruser out 1, rvalid out 1; rready in 1.

## Operation
- Memory: 2^addr_width words plus one "written" flag per word. Reset clears all words to 0 and all flags.
- Write path flags aw_full and w_full. awready = !aw_full; wready = !w_full.
- AW handshake (awvalid && awready) latches awaddr and awid and sets aw_full. W handshake latches wdata and sets w_full. The two handshakes may occur on the same edge or on different edges.
- When aw_full && w_full && !bvalid: write the latched data to mem[addr] as a full word (wstrb ignored), set written[addr], assert bvalid with bresp=OKAY (2'b00) and bid = latched awid.
- B handshake (bvalid && bready): clear bvalid, aw_full and w_full. No new AW or W is accepted until this completes.
- Read: arready = !rvalid. An AR handshake registers rvalid=1, rid=arid, rlast=1, and rdata=mem[araddr] with rresp=OKAY if written[araddr]; otherwise rdata=0 and rresp=SLVERR (2'b10). Output is held until rready; the R handshake clears rvalid.
- Read and write paths are independent and may be active concurrently. If a memory write and an AR to the same address occur on the same edge, the read returns the old value.
- Ignored inputs: awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, wid, wlast, wuser, and their AR equivalents. buser=0 and ruser=0 at all times.

## Timing
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=0, bid=0, rvalid=0, rdata=0, rresp=0, rid=0, rlast=0.
- Reset asserted mid-transaction aborts it; all pending state is cleared.
- Write response: bvalid rises one edge after the later of the AW and W handshakes.
- Read data: rvalid rises on the AR handshake edge, i.e. visible the cycle after arvalid is sampled.
- Valid outputs and their payloads stay stable until the corresponding ready handshake.

## Structure
- Shared package axi_pkg: RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus default widths.
- One sub-module, axi_slave_mem: memory array with written flags, one synchronous write port and one read port.
- The handshake logic for the AW/W/B and AR/R channels lives in the top module.

## Test plan
- Address before data (AW at addr 1, then W 5, then bready) -> one bvalid pulse with bresp=0; subsequent read of addr 1 returns rdata=5, rresp=0, rlast=1.
- Data before address (W 10, then AW at addr 2) -> bvalid with bresp=0; read of addr 2 returns 10.
- AW and W in the same cycle (addr 3, data 20) -> bvalid asserted the next edge; read of addr 3 returns 20.
- Read of never-written addr 5 -> rdata=0, rresp=2'b10.
- Write to addr 2 concurrent with read of addr 1 -> both complete with correct data. Read of addr 3 issued on the same edge as its write -> returns the old value.
- Assert aresetn low while bvalid is pending -> bvalid=0 and awready=1 immediately; read of any address after reset returns SLVERR.
